// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// sign fix-up in a final cycle, combinational busy so the pipeline freezes in the start cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for i_start; results from the last division held
// S_CALC | WIDTH shift/trial-subtract steps on |dividend| / |divisor|
// S_FIX  | apply signs or divide-by-zero values, register results
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvnd_q, dvnd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmdr_q, rmdr_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] abs_dvnd;
  logic [WIDTH-1:0] abs_dvsr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    dvnd_d    = dvnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    quot_d    = quot_q;
    rmdr_d    = rmdr_q;
    dbz_d     = dbz_q;

    // Magnitudes stay unsigned, so |-2^(WIDTH-1)| is exact.
    abs_dvnd = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
    abs_dvsr = (i_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {2'b00, dvsr_q};

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_cancel) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = abs_dvnd;
          dvsr_d    = abs_dvsr;
          dvnd_d    = i_dividend;
          neg_quo_d = i_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
          neg_rem_d = i_signed && i_dividend[WIDTH-1];
          dz_d      = (i_divisor == '0);
        end
      end
      S_CALC: begin
        if (i_cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (!diff[WIDTH+1]) begin
            rem_d = diff[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!i_cancel) begin
          done_d = 1'b1;
          dbz_d  = dz_q;
          if (dz_q) begin
            quot_d = '1;
            rmdr_d = dvnd_q;
          end else begin
            quot_d = neg_quo_q ? -quo_q : quo_q;
            rmdr_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      dvnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rmdr_q    <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      dvnd_q    <= dvnd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      rmdr_q    <= rmdr_d;
      dbz_q     <= dbz_d;
    end
  end

  assign o_busy        = ((state_q == S_IDLE) && i_start && !i_cancel) || (state_q != S_IDLE);
  assign o_done        = done_q;
  assign o_quotient    = quot_q;
  assign o_remainder   = rmdr_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS DIV/DIVU cases, cancel, reset and
// back-to-back starts, plus random operands checked against an arithmetic reference.
module tb_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_start, i_signed, i_cancel;
  logic [W-1:0]  i_dividend, i_divisor;
  logic          o_busy, o_done, o_div_by_zero;
  logic [W-1:0]  o_quotient, o_remainder;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_signed(i_signed),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .i_cancel(i_cancel),
    .o_busy(o_busy), .o_done(o_done), .o_quotient(o_quotient),
    .o_remainder(o_remainder), .o_div_by_zero(o_div_by_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // MIPS semantics straight from arithmetic: C-style truncating division on 64-bit values.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit b2b);
    logic [W-1:0] eq, er;
    logic         edz;
    int           lat, nbusy;
    ref_div(a, b, s, eq, er, edz);
    if (!b2b) @(negedge clk);
    i_start = 1'b1; i_signed = s; i_dividend = a; i_divisor = b;
    #1;
    lat = 0; nbusy = 0;
    while ((lat == 0 || o_done !== 1'b1) && lat < 60) begin
      if (o_busy === 1'b1) nbusy++;
      @(negedge clk);
      i_start = 1'b0;
      i_dividend = $urandom; i_divisor = $urandom; i_signed = 1'($urandom_range(0, 1));
      #1;
      lat++;
    end
    check($sformatf("latency %h/%h s=%0d", a, b, s), W'(lat), W'(W + 2));
    check($sformatf("busy_span %h/%h", a, b), W'(nbusy), W'(W + 2));
    check("busy_in_done_cycle", W'(o_busy), W'(0));
    check($sformatf("quotient %h/%h s=%0d", a, b, s), o_quotient, eq);
    check($sformatf("remainder %h/%h s=%0d", a, b, s), o_remainder, er);
    check($sformatf("div_by_zero %h/%h", a, b), W'(o_div_by_zero), W'(edz));
  endtask

  // Cancel in the cycle k after the start cycle (k=1..W is CALC, W+1 is FIX).
  task automatic cancel_op(input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                           input logic [W-1:0] hq, input logic [W-1:0] hr);
    int bad;
    @(negedge clk);
    i_start = 1'b1; i_signed = 1'b0; i_dividend = a; i_divisor = b;
    #1;
    repeat (k) begin
      @(negedge clk); i_start = 1'b0; #1;
    end
    i_cancel = 1'b1;
    #1;
    check($sformatf("busy_in_cancel_cycle k=%0d", k), W'(o_busy), W'(1));
    @(negedge clk); i_cancel = 1'b0; #1;
    check($sformatf("busy_after_cancel k=%0d", k), W'(o_busy), W'(0));
    check($sformatf("done_after_cancel k=%0d", k), W'(o_done), W'(0));
    check($sformatf("quotient_held k=%0d", k), o_quotient, hq);
    check($sformatf("remainder_held k=%0d", k), o_remainder, hr);
    bad = 0;
    repeat (W + 4) begin
      @(negedge clk); #1;
      if (o_done === 1'b1 || o_busy === 1'b1) bad++;
    end
    check($sformatf("quiet_after_cancel k=%0d", k), W'(bad), W'(0));
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           sel, bad;

    resetn = 1'b0; i_start = 1'b0; i_signed = 1'b0; i_cancel = 1'b0;
    i_dividend = '0; i_divisor = '0;
    #3;
    check("reset_busy", W'(o_busy), W'(0));
    check("reset_done", W'(o_done), W'(0));
    check("reset_quotient", o_quotient, W'(0));
    check("reset_remainder", o_remainder, W'(0));
    check("reset_dbz", W'(o_div_by_zero), W'(0));
    @(negedge clk); resetn = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'd2, 1'b1, 1'b0);
    run_op(32'h0000_1234, 32'd0, 1'b1, 1'b0);
    run_op(32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);

    @(negedge clk); #1;
    check("done_one_cycle", W'(o_done), W'(0));
    check("dz_result_held", o_remainder, 32'hFFFF_FF00);

    run_op(32'd9, 32'd4, 1'b0, 1'b0);
    cancel_op(32'd100, 32'd7, 10, 32'd2, 32'd1);
    cancel_op(32'd1000, 32'd3, W + 1, 32'd2, 32'd1);

    @(negedge clk);
    i_start = 1'b1; i_cancel = 1'b1; i_dividend = 32'd40; i_divisor = 32'd8;
    #1;
    check("busy_cancel_with_start", W'(o_busy), W'(0));
    @(negedge clk); i_start = 1'b0; i_cancel = 1'b0; #1;
    bad = 0;
    repeat (W + 4) begin
      @(negedge clk); #1;
      if (o_done === 1'b1 || o_busy === 1'b1) bad++;
    end
    check("quiet_cancel_with_start", W'(bad), W'(0));
    check("quotient_after_idle_cancel", o_quotient, 32'd2);

    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    run_op(32'd50, 32'd5, 1'b0, 1'b1);

    @(negedge clk);
    i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd77; i_divisor = 32'd3;
    #1;
    repeat (6) begin
      @(negedge clk); i_start = 1'b0; #1;
    end
    resetn = 1'b0;
    #1;
    check("midcalc_reset_busy", W'(o_busy), W'(0));
    check("midcalc_reset_done", W'(o_done), W'(0));
    check("midcalc_reset_quotient", o_quotient, W'(0));
    check("midcalc_reset_remainder", o_remainder, W'(0));
    check("midcalc_reset_dbz", W'(o_div_by_zero), W'(0));
    @(negedge clk); resetn = 1'b1;
    run_op(32'd9, 32'd4, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      case (sel)
        0: b = '0;
        1: b = '1;
        2: a = 32'h8000_0000;
        3: b = W'($urandom_range(1, 17));
        4: b = {1'b1, W'($urandom_range(0, 255))} >> 0;
        default: ;
      endcase
      run_op(a, b, s, (i % 3) == 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 restoring divider serving the MIPS DIV/DIVU instructions from the EXE stage. It produces the `o_busy` level that the pipeline controller samples to freeze all stage registers while a division is in flight. On completion it delivers the quotient (LO) and remainder (HI) to the HI/LO write path with a one-cycle done pulse.

## Interface

- `WIDTH`, default 32, operand and result width in bits. Must be ≥ 2.
- `clk` input 1: system clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `i_start` input 1: start request, sampled on the rising edge. Honoured only in IDLE.
- `i_signed` input 1: 1 selects DIV (two's complement), 0 selects DIVU. Captured with `i_start`.
- `i_dividend` input WIDTH: dividend (rs), captured with `i_start`.
- `i_divisor` input WIDTH: divisor (rt), captured with `i_start`.
- `i_cancel` input 1: abort on exception flush. Effective in any state.
- `o_busy` output 1: stall request to the pipeline controller.
- `o_done` output 1: one-cycle pulse. Results are valid in the same cycle.
- `o_quotient` output WIDTH: quotient, written to LO.
- `o_remainder` output WIDTH: remainder, written to HI.
- `o_div_by_zero` output 1: the last completed division had divisor 0.

## Operation

- States are IDLE, CALC and FIX.
- IDLE:
  - If `i_start` = 1 and `i_cancel` = 0, capture operands and signs, then go to CALC with the step counter at 0.
  - Operand capture: load |dividend| into the working quotient/shift register and clear the partial remainder (WIDTH+1 bits).
  - Absolute value is taken only when `i_signed` = 1. |−2^(WIDTH−1)| = 2^(WIDTH−1) must be represented as unsigned, with no overflow.
- CALC, one step per cycle, WIDTH cycles:
  - Shift {rem, quo} left by 1.
  - Trial-subtract |divisor| from rem.
  - If the result is non-negative, rem = difference and quo LSB = 1. Otherwise rem is unchanged and quo LSB = 0.
  - After step WIDTH−1, go to FIX.
- FIX:
  - Apply signs when `i_signed` = 1: quotient negated iff the dividend and divisor signs differ; remainder negated iff the dividend is negative. Quotient truncates toward zero.
  - Register `o_quotient`, `o_remainder` and `o_div_by_zero`. Assert `o_done` for the next cycle. Go to IDLE.
- Divide by zero, both modes: `o_quotient` = all ones, `o_remainder` = raw `i_dividend` as captured, `o_div_by_zero` = 1. No sign fix is applied.
- Signed overflow: −2^(WIDTH−1) / −1 gives quotient 0x8000_0000 (for WIDTH = 32), remainder 0, `o_div_by_zero` = 0.
- Operand inputs are ignored after capture.
- `i_start` is ignored in CALC and FIX.
- `i_cancel` in CALC or FIX:
  - Next state is IDLE and no `o_done` is produced.
  - `o_quotient`, `o_remainder` and `o_div_by_zero` keep their previous values.
- `i_cancel` together with `i_start` in IDLE: cancel wins and nothing starts.
- Async reset mid-operation returns to IDLE immediately. Any in-flight result is lost.

## Timing

- Reset values:
  - `o_busy` = 0, `o_done` = 0, `o_quotient` = 0, `o_remainder` = 0, `o_div_by_zero` = 0.
  - State IDLE, counter 0.
- `o_busy` = (IDLE & `i_start` & ~`i_cancel`) | CALC | FIX.
  - The busy term from IDLE is combinational, so the controller sees busy in the start cycle itself.
  - All other outputs are registered.
- Let cycle S be the start cycle (IDLE, `i_start` sampled at the end of S).
  - CALC occupies cycles S+1 … S+WIDTH.
  - FIX occupies cycle S+WIDTH+1.
  - `o_done` = 1 and results are valid in cycle S+WIDTH+2, with `o_busy` = 0 there.
- Total `o_busy` = 1 span is WIDTH+2 cycles (34 for WIDTH = 32).
- Results are held stable until the next FIX completes.
- A new `i_start` in the `o_done` cycle is legal and begins a new operation. `o_done` still drops the next cycle.
- `i_cancel` sampled at the end of cycle C (CALC or FIX) gives `o_busy` = 0 in cycle C+1.

## Test plan

- **Unsigned:** DIVU 100 / 7 → `o_busy` high for 34 cycles, then `o_done` with quotient 14, remainder 2, `o_div_by_zero` = 0.
- **Signed sign rules:**
  - DIV −7 / 2 → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF.
  - DIV 7 / −2 → quotient 0xFFFF_FFFD, remainder 1.
  - DIVU 0xFFFF_FFFF / 2 → quotient 0x7FFF_FFFF, remainder 1.
- **Edge operands:**
  - DIV 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0.
  - DIV 0x8000_0000 / 2 → quotient 0xC000_0000, remainder 0.
- **Divide by zero:** DIV 0x1234 / 0 → quotient 0xFFFF_FFFF, remainder 0x1234, `o_div_by_zero` = 1, same 34-cycle latency.
- **Cancel:**
  - Start 100 / 7 after a completed 9 / 4 (quotient 2, remainder 1). Pulse `i_cancel` in the 10th CALC cycle.
  - Expected: `o_busy` = 0 next cycle, no `o_done`, outputs still 2 / 1.
  - Cancel asserted together with start in IDLE: no busy, no done.
- **Back-to-back and reset:**
  - Start 50 / 5 in the `o_done` cycle of the previous op → correct 10 / 0 exactly 34 cycles later.
  - Drop `resetn` mid-CALC → `o_busy`, `o_done` and all results are 0 immediately.
  - After release, a fresh 9 / 4 completes normally.
